// File: rtl/router_out_arbiter.sv
// Per-output switch allocator: round-robin, packet-locked (wormhole) arbitration
// of NUM_INPUTS AXI-Stream inputs onto one registered output link.
module router_out_arbiter #(
    parameter int NUM_INPUTS  = 5,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                              clk_noc,
    input  logic                              rst,
    input  logic [NUM_INPUTS-1:0]             in_tvalid,
    output logic [NUM_INPUTS-1:0]             in_tready,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_INPUTS-1:0]             in_tlast,
    input  logic [NUM_INPUTS*TID_WIDTH-1:0]   in_tid,
    input  logic [NUM_INPUTS*TDEST_WIDTH-1:0] in_tdest,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    output logic [TDATA_WIDTH-1:0]            out_tdata,
    output logic                              out_tlast,
    output logic [TID_WIDTH-1:0]              out_tid,
    output logic [TDEST_WIDTH-1:0]            out_tdest,
    output logic [NUM_INPUTS-1:0]             grant,
    output logic                              busy
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state, state_next;
    logic [NUM_INPUTS-1:0]   grant_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [IDX_W-1:0]        last, last_next;
    logic [IDX_W-1:0]        pick;
    logic                    found;
    logic                    out_free;
    logic                    xfer;
    logic                    xfer_last;
    logic [TDATA_WIDTH-1:0]  sel_data;
    logic                    sel_last;
    logic [TID_WIDTH-1:0]    sel_id;
    logic [TDEST_WIDTH-1:0]  sel_dest;

    // Round-robin search: inputs above the pointer first, then wrap to 0..last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && in_tvalid[i] && i > int'(last)) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && in_tvalid[i] && i <= int'(last)) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_id   = '0;
        sel_dest = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_data = in_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
                sel_last = in_tlast[i];
                sel_id   = in_tid[i*TID_WIDTH +: TID_WIDTH];
                sel_dest = in_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
            end
        end
    end

    assign out_free  = !out_tvalid || out_tready;
    assign in_tready = (state == LOCKED && out_free) ? grant : '0;
    assign xfer      = |(in_tvalid & in_tready);
    assign xfer_last = xfer && sel_last;
    assign busy      = (state == LOCKED);

    always_comb begin
        state_next = state;
        grant_next = grant;
        idx_next   = idx;
        last_next  = last;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next = LOCKED;
                    grant_next = NUM_INPUTS'(1) << pick;
                    idx_next   = pick;
                end
            end
            LOCKED: begin
                if (xfer_last) begin
                    state_next = IDLE;
                    grant_next = '0;
                    last_next  = idx;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            idx   <= '0;
            last  <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            idx   <= idx_next;
            last  <= last_next;
        end
    end

    // Single output stage; load and drain in the same cycle keeps 1 flit/cycle.
    always_ff @(posedge clk_noc) begin
        if (rst) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            out_tid    <= '0;
            out_tdest  <= '0;
        end else if (xfer) begin
            out_tvalid <= 1'b1;
            out_tdata  <= sel_data;
            out_tlast  <= sel_last;
            out_tid    <= sel_id;
            out_tdest  <= sel_dest;
        end else if (out_tvalid && out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed self-checking bench for router_out_arbiter (5 inputs, 32-bit flits).
module tb_router_out_arbiter;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int DW = 4;

    logic            clk_noc = 1'b0;
    logic            rst;
    logic [N-1:0]    in_tvalid;
    logic [N-1:0]    in_tready;
    logic [N*W-1:0]  in_tdata;
    logic [N-1:0]    in_tlast;
    logic [N*IW-1:0] in_tid;
    logic [N*DW-1:0] in_tdest;
    logic            out_tvalid;
    logic            out_tready;
    logic [W-1:0]    out_tdata;
    logic            out_tlast;
    logic [IW-1:0]   out_tid;
    logic [DW-1:0]   out_tdest;
    logic [N-1:0]    grant;
    logic            busy;

    int checks = 0;
    int errors = 0;

    router_out_arbiter #(
        .NUM_INPUTS(N),
        .TDATA_WIDTH(W),
        .TID_WIDTH(IW),
        .TDEST_WIDTH(DW)
    ) dut (
        .clk_noc(clk_noc),
        .rst(rst),
        .in_tvalid(in_tvalid),
        .in_tready(in_tready),
        .in_tdata(in_tdata),
        .in_tlast(in_tlast),
        .in_tid(in_tid),
        .in_tdest(in_tdest),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tdata(out_tdata),
        .out_tlast(out_tlast),
        .out_tid(out_tid),
        .out_tdest(out_tdest),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic set_flit(input int i, input logic [W-1:0] d, input logic l);
        in_tdata[i*W +: W]    = d;
        in_tlast[i]           = l;
        in_tid[i*IW +: IW]    = IW'(i);
        in_tdest[i*DW +: DW]  = DW'(i + 8);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tlast   = '0;
        in_tid     = '0;
        in_tdest   = '0;
        out_tready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_tvalid  = 5'b11111;
        in_tdata   = '0;
        in_tlast   = '0;
        in_tid     = '0;
        in_tdest   = '0;
        out_tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({in_tready, out_tvalid, grant, busy} !== 12'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d tready=%b ovalid=%b grant=%b busy=%b exp all 0",
                         c, in_tready, out_tvalid, grant, busy);
            end
        end
        checks++;
        if ({out_tdata, out_tlast, out_tid, out_tdest} !== '0) begin
            errors++;
            $display("FAIL reset_outregs got %h/%b/%h/%h exp 0",
                     out_tdata, out_tlast, out_tid, out_tdest);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 5'b00001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got %b busy %b exp 00001 busy 1", grant, busy);
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        set_flit(2, 32'hA0, 1'b0);
        in_tvalid = 5'b00100;
        tick();
        checks++;
        if (grant !== 5'b00100 || out_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pkt_grant got %b ovalid %b exp 00100 ovalid 0", grant, out_tvalid);
        end
        checks++;
        if (in_tready !== 5'b00100) begin
            errors++;
            $display("FAIL pkt_tready got %b exp 00100", in_tready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({out_tvalid, out_tlast, out_tdata} !== {1'b1, k == 3, 32'hA0 + W'(k)}) begin
                errors++;
                $display("FAIL pkt_flit%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         k, out_tvalid, out_tlast, out_tdata, k == 3, 32'hA0 + W'(k));
            end
            if (k < 3) set_flit(2, 32'hA0 + W'(k + 1), k == 2);
            else in_tvalid = '0;
        end
        checks++;
        if ({busy, grant, out_tid, out_tdest} !== {1'b0, 5'b0, 2'd2, 4'd10}) begin
            errors++;
            $display("FAIL pkt_end got busy=%b grant=%b tid=%h tdest=%h exp 0 00000 2 a",
                     busy, grant, out_tid, out_tdest);
        end
        tick();
        checks++;
        if (out_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pkt_drain got ovalid %b exp 0", out_tvalid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_flit(i, W'(i * 16), 1'b1);
        in_tvalid = 5'b11111;
        for (int p = 0; p < 7; p++) begin
            tick();
            checks++;
            if (grant !== N'(1 << (p % N)) || out_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL rr_grant%0d got %b ovalid %b exp %b ovalid 0",
                         p, grant, out_tvalid, N'(1 << (p % N)));
            end
            tick();
            checks++;
            if (out_tvalid !== 1'b1 || out_tdata !== W'((p % N) * 16) || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_data%0d got v=%b d=%h busy=%b exp v=1 d=%h busy=0",
                         p, out_tvalid, out_tdata, busy, W'((p % N) * 16));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_flit(1, 32'hB0, 1'b0);
        in_tvalid = 5'b00010;
        tick();
        tick();
        set_flit(1, 32'hB1, 1'b0);
        out_tready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_tready !== 5'b0) begin
                errors++;
                $display("FAIL bp_tready cyc %0d got %b exp 00000", c, in_tready);
            end
            tick();
            checks++;
            if (out_tvalid !== 1'b1 || out_tdata !== 32'hB0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h exp v=1 d=b0",
                         c, out_tvalid, out_tdata);
            end
        end
        out_tready = 1'b1;
        #1;
        checks++;
        if (in_tready !== 5'b00010) begin
            errors++;
            $display("FAIL bp_release got %b exp 00010", in_tready);
        end
        tick();
        checks++;
        if ({out_tvalid, out_tlast, out_tdata} !== {2'b10, 32'hB1}) begin
            errors++;
            $display("FAIL bp_flit1 got v=%b l=%b d=%h exp v=1 l=0 d=b1",
                     out_tvalid, out_tlast, out_tdata);
        end
        set_flit(1, 32'hB2, 1'b1);
        tick();
        checks++;
        if ({out_tvalid, out_tlast, out_tdata} !== {2'b11, 32'hB2}) begin
            errors++;
            $display("FAIL bp_flit2 got v=%b l=%b d=%h exp v=1 l=1 d=b2",
                     out_tvalid, out_tlast, out_tdata);
        end
        in_tvalid = '0;
        tick();
        checks++;
        if (out_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_nodup got v=%b busy=%b exp 0 0", out_tvalid, busy);
        end
    endtask

    task automatic test_wormhole();
        do_reset();
        set_flit(3, 32'hC0, 1'b0);
        in_tvalid = 5'b01000;
        tick();
        tick();
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== 32'hC0) begin
            errors++;
            $display("FAIL wh_first got v=%b d=%h exp v=1 d=c0", out_tvalid, out_tdata);
        end
        set_flit(0, 32'hD0, 1'b1);
        set_flit(3, 32'hC1, 1'b1);
        in_tvalid = 5'b00001;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== 5'b01000 || busy !== 1'b1 || in_tready[0] !== 1'b0) begin
                errors++;
                $display("FAIL wh_lock cyc %0d got grant=%b busy=%b rdy0=%b exp 01000 1 0",
                         c, grant, busy, in_tready[0]);
            end
        end
        in_tvalid = 5'b01001;
        tick();
        checks++;
        if ({grant, out_tlast, out_tdata} !== {5'b0, 1'b1, 32'hC1}) begin
            errors++;
            $display("FAIL wh_tail got grant=%b l=%b d=%h exp 00000 1 c1",
                     grant, out_tlast, out_tdata);
        end
        in_tvalid = 5'b00001;
        tick();
        checks++;
        if (grant !== 5'b00001) begin
            errors++;
            $display("FAIL wh_next_grant got %b exp 00001", grant);
        end
        tick();
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== 32'hD0) begin
            errors++;
            $display("FAIL wh_next_data got v=%b d=%h exp v=1 d=d0", out_tvalid, out_tdata);
        end
        in_tvalid = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_flit(4, 32'hE0, 1'b0);
        in_tvalid = 5'b10000;
        tick();
        tick();
        set_flit(4, 32'hE1, 1'b0);
        tick();
        set_flit(4, 32'hE2, 1'b0);
        rst = 1'b1;
        tick();
        checks++;
        if ({out_tvalid, busy, grant, out_tdata} !== '0) begin
            errors++;
            $display("FAIL rstmid got v=%b busy=%b grant=%b d=%h exp all 0",
                     out_tvalid, busy, grant, out_tdata);
        end
        rst = 1'b0;
        set_flit(0, 32'hF0, 1'b1);
        in_tvalid = 5'b10001;
        tick();
        checks++;
        if (grant !== 5'b00001) begin
            errors++;
            $display("FAIL rstmid_ptr got %b exp 00001", grant);
        end
        tick();
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== 32'hF0) begin
            errors++;
            $display("FAIL rstmid_data got v=%b d=%h exp v=1 d=f0", out_tvalid, out_tdata);
        end
        in_tvalid = '0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_wormhole();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port switch allocator for the 5-port mesh NoC router.
- Shares one AXI-Stream output link between NUM_INPUTS input ports with round-robin fairness.
- Locks the grant for a whole packet (wormhole: the grant is held from the first flit through the tlast flit).
- Drives the output through a single registered pipeline stage. One instance sits in front of each router output: top, right, bottom, left and local.

Parameters:
NUM_INPUTS, 5, number of requesting input ports (2..8)
TDATA_WIDTH, 32, flit payload width
TID_WIDTH, 2, AXI-Stream tid width
TDEST_WIDTH, 4, AXI-Stream tdest width

Ports:
clk_noc  in  1  NoC clock; the block has one clock and all logic is on its rising edge
rst  in  1  synchronous, active-high reset
in_tvalid  in  NUM_INPUTS  per-input flit valid
in_tready  out  NUM_INPUTS  per-input flit accept
in_tdata  in  NUM_INPUTS*TDATA_WIDTH  flattened payload; input i occupies [i*TDATA_WIDTH +: TDATA_WIDTH]
in_tlast  in  NUM_INPUTS  per-input end-of-packet
in_tid  in  NUM_INPUTS*TID_WIDTH  flattened tid
in_tdest  in  NUM_INPUTS*TDEST_WIDTH  flattened tdest
out_tvalid  out  1  registered output valid
out_tready  in  1  downstream accept
out_tdata  out  TDATA_WIDTH  registered payload
out_tlast  out  1  registered end-of-packet
out_tid  out  TID_WIDTH  registered tid
out_tdest  out  TDEST_WIDTH  registered tdest
grant  out  NUM_INPUTS  one-hot current owner; all zero when IDLE
busy  out  1  1 in LOCKED state

Behaviour:
- Reset (rst=1 at a clock edge, synchronous, overrides everything):
  - state=IDLE, grant=0, busy=0, in_tready=0.
  - out_tvalid=0; out_tdata, out_tlast, out_tid and out_tdest all 0.
  - Round-robin pointer last=NUM_INPUTS-1, so input 0 has top priority after reset.
  - Reset mid-packet drops the in-flight packet and any flit held in the output register.
- FSM states: IDLE and LOCKED.
- IDLE:
  - in_tready=0.
  - If any in_tvalid is set, select the first valid input scanning last+1, last+2, ... modulo NUM_INPUTS.
  - Register its one-hot value into grant and move to LOCKED.
  - Arbitration takes 1 cycle, so the first flit is accepted no earlier than the cycle after tvalid is first seen in IDLE.
- LOCKED:
  - in_tready[g] = (!out_tvalid || out_tready) for the granted input g.
  - in_tready is 0 for every other input.
  - A flit transfers when in_tvalid[g] && in_tready[g]. It loads the output register, setting out_tvalid=1 and copying the tdata, tlast, tid and tdest slices of input g.
- Output register:
  - On out_tvalid && out_tready with no new load, clear out_tvalid. The data fields may hold their values.
  - A simultaneous drain and load keeps out_tvalid=1 with the new flit, giving full throughput of 1 flit/cycle.
  - While out_tvalid && !out_tready, the register holds stable and in_tready[g]=0; AXI-Stream stability is required.
- Packet end:
  - A transfer with in_tlast[g]=1 sets last=g, clears grant and returns to IDLE.
  - The next arbitration happens in the following cycle, so there is exactly 1 bubble cycle between packets on the input side.
  - The output register may still be draining during this cycle; this is legal.
- Single-flit packet (tlast on the first flit): LOCKED lasts exactly 1 accepted flit.
- Valid dropping mid-packet (in_tvalid[g]=0): remain LOCKED indefinitely. There is no timeout and no preemption.
- Non-granted inputs: requests from other inputs while LOCKED are ignored. Their tvalid must stay asserted per AXI-Stream, and the block never accepts from them.
- Fairness: with all inputs requesting continuously, grant order is 0,1,2,...,NUM_INPUTS-1,0,... Any input waits at most NUM_INPUTS-1 packets.
- busy=1 exactly when the state is LOCKED. grant is always one-hot or zero.

Test Plan:
1. Reset then idle: hold rst=1 for 3 cycles with in_tvalid=5'b11111 -> in_tready=0, out_tvalid=0, grant=0. After releasing rst, the first grant is 5'b00001.
2. Single input, 4-flit packet: input 2 sends tdata 0xA0..0xA3 with tlast on 0xA3, out_tready=1.
   - grant=5'b00100 one cycle after tvalid.
   - out_tdata shows 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, with out_tlast only on 0xA3.
   - busy drops after the 0xA3 transfer.
3. Round-robin rotation: all 5 inputs continuously send 1-flit packets (tdata=0x10*i) -> out_tdata sequence 0x00, 0x10, 0x20, 0x30, 0x40, 0x00, ... with 1 bubble between packets.
4. Backpressure: input 1 streams 3 flits while out_tready is held 0 for 5 cycles after the first flit -> in_tready[1]=0 and out_tdata stable at flit 0 throughout. No flit is lost or duplicated after out_tready=1.
5. Wormhole lock: input 3 stalls its tvalid mid-packet for 4 cycles while input 0 requests -> grant stays 5'b01000. Input 0 is granted only after input 3's tlast.
6. Reset mid-packet: assert rst during flit 2 of a 4-flit packet from input 4 -> next cycle out_tvalid=0 and state IDLE. The pointer resets, so input 0 wins the next contention against input 4.
